ac_symbol_feeder: RTL and testbench

Upstream feed stage for the Aho-Corasick matcher core. It accepts 4-bit text symbols over a valid/ready handshake and buffers them in a small FIFO. It then drives the matcher's EN / INITIALIZE / STRING inputs with a fixed two-cycle cadence per symbol: a FEED cycle followed by an INIT cycle. This replaces hand-sequenced stimulus and lets the matcher be fed from any upstream source at line rate minus backpressure.

---
 rtl/ac_pkg.sv | 24 ++
 rtl/ac_symbol_feeder_if.sv | 37 +++
 rtl/ac_sym_fifo.sv | 52 +++++
 rtl/ac_symbol_feeder.sv | 108 ++++++++++
 tb/tb_ac_symbol_feeder.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ac_pkg.sv
// Shared types and constants for the Aho-Corasick symbol feeder and its FIFO.
package ac_pkg;

    localparam int unsigned SYM_W = 4;
    localparam int unsigned POS_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StInit,
        StDone
    } feeder_state_e;

    typedef struct packed {
        logic             last;
        logic [SYM_W-1:0] sym;
    } fifo_entry_t;

    // Occupancy counter width: one extra bit so a full FIFO is distinguishable from empty.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ac_symbol_feeder_if.sv
// Upstream handshake and matcher-side signals of the symbol feeder.
// SYM_POS exists only when AC_SYM_POS_EN is defined.
interface ac_symbol_feeder_if;
    import ac_pkg::*;

    logic             IN_VALID;
    logic             IN_READY;
    logic [SYM_W-1:0] IN_SYM;
    logic             IN_LAST;
    logic             EN;
    logic             INITIALIZE;
    logic [SYM_W-1:0] STRING;
    logic             BUSY;
    logic             TEXT_DONE;
`ifdef AC_SYM_POS_EN
    logic [POS_W-1:0] SYM_POS;

    modport master (
        output IN_VALID, IN_SYM, IN_LAST,
        input  IN_READY, EN, INITIALIZE, STRING, BUSY, TEXT_DONE, SYM_POS
    );
    modport slave (
        input  IN_VALID, IN_SYM, IN_LAST,
        output IN_READY, EN, INITIALIZE, STRING, BUSY, TEXT_DONE, SYM_POS
    );
`else
    modport master (
        output IN_VALID, IN_SYM, IN_LAST,
        input  IN_READY, EN, INITIALIZE, STRING, BUSY, TEXT_DONE
    );
    modport slave (
        input  IN_VALID, IN_SYM, IN_LAST,
        output IN_READY, EN, INITIALIZE, STRING, BUSY, TEXT_DONE
    );
`endif

endinterface

// File: rtl/ac_sym_fifo.sv
// Synchronous FIFO of {last, symbol} entries; DEPTH must be a power of two.
module ac_sym_fifo
    import ac_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CntW = cnt_w(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  fifo_entry_t     push_data_i,
    input  logic            pop_i,
    output fifo_entry_t     pop_data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    fifo_entry_t     mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o     = (count_q == CntW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ac_symbol_feeder.sv
// Feeds buffered text symbols to the matcher as FEED/INIT pairs, with a DONE cycle per text.
// Optional AC_SYM_POS_EN adds an 8-bit saturating symbol position output.
module ac_symbol_feeder
    import ac_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input logic               CLK,
    input logic               RST,
    ac_symbol_feeder_if.slave bus
);

    localparam int unsigned CntW = cnt_w(DEPTH);

    feeder_state_e    state_q, state_d;
    logic             push, pop;
    logic             fifo_full, fifo_empty;
    logic [CntW-1:0]  fifo_count, count_nxt;
    fifo_entry_t      push_entry, head;

    logic             in_ready_q;
    logic             en_q, init_q, done_q, busy_q, last_q;
    logic [SYM_W-1:0] string_q;

    assign push       = bus.IN_VALID && in_ready_q && !fifo_full;
    assign push_entry = {bus.IN_LAST, bus.IN_SYM};
    assign pop        = (state_d == StFeed);
    assign count_nxt  = fifo_count + CntW'(push) - CntW'(pop);

    ac_sym_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (CLK),
        .rst_i       (RST),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (!fifo_empty) state_d = StFeed;
            StFeed:  state_d = StInit;
            StInit: begin
                if (last_q)           state_d = StDone;
                else if (!fifo_empty) state_d = StFeed;
                else                  state_d = StIdle;
            end
            StDone:  state_d = fifo_empty ? StIdle : StFeed;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            in_ready_q <= 1'b0;
            en_q       <= 1'b0;
            init_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            last_q     <= 1'b0;
            string_q   <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (count_nxt != CntW'(DEPTH));
            en_q       <= (state_d == StFeed);
            init_q     <= (state_d == StInit);
            done_q     <= (state_d == StDone);
            busy_q     <= (state_d != StIdle) || (count_nxt != '0);
            if (pop) begin
                string_q <= head.sym;
                last_q   <= head.last;
            end
        end
    end

    assign bus.IN_READY   = in_ready_q;
    assign bus.EN         = en_q;
    assign bus.INITIALIZE = init_q;
    assign bus.STRING     = string_q;
    assign bus.BUSY       = busy_q;
    assign bus.TEXT_DONE  = done_q;

`ifdef AC_SYM_POS_EN
    logic [POS_W-1:0] pos_q;

    // Counts completed FEEDs within the current text; cleared as DONE is entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pos_q <= '0;
        end else if (state_d == StDone) begin
            pos_q <= '0;
        end else if (state_q == StFeed && pos_q != '1) begin
            pos_q <= pos_q + 1'b1;
        end
    end

    assign bus.SYM_POS = pos_q;
`endif

endmodule

// File: tb/tb_ac_symbol_feeder.sv
// Bench for ac_symbol_feeder: directed scenarios plus an in-order scoreboard on the EN stream.
module tb_ac_symbol_feeder;
    import ac_pkg::*;

    logic CLK;
    logic RST;

    ac_symbol_feeder_if bus();

    ac_symbol_feeder #(
        .DEPTH (16)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int         checks = 0;
    int         errors = 0;
    logic [4:0] exp_q[$];
    bit         pend_init, pend_last, pend_done;
    int         done_cnt = 0;
    bit         chk_occ = 0;
    bit         saw_full = 0;
    int         acc_cnt = 0;
    int         pop_cnt = 0;
    logic [8:0] obs;  // {ready, en, init, done, busy, string}
`ifdef AC_SYM_POS_EN
    int         obs_pos;
`endif

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // One clock of stimulus; samples outputs at the falling edge.
    task automatic step(input bit v, input logic [3:0] sym, input bit last, output bit accepted);
        bus.IN_VALID = v;
        bus.IN_SYM   = sym;
        bus.IN_LAST  = last;
        @(negedge CLK);
        obs = {bus.IN_READY, bus.EN, bus.INITIALIZE, bus.TEXT_DONE, bus.BUSY, bus.STRING};
`ifdef AC_SYM_POS_EN
        obs_pos = int'(bus.SYM_POS);
`endif
        if (bus.EN) pop_cnt++;
        if (chk_occ) begin
            check_eq("in_ready_vs_occupancy", int'(bus.IN_READY),
                     int'((acc_cnt - pop_cnt) != 16));
            if (!bus.IN_READY) saw_full = 1'b1;
        end
        accepted = v && bus.IN_READY;
        if (accepted) exp_q.push_back({last, sym});
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        if (accepted) acc_cnt++;
    endtask

    task automatic send(input logic [3:0] sym, input bit last);
        bit a;
        int n;
        a = 1'b0;
        n = 0;
        while (!a && n < 200) begin
            step(1'b1, sym, last, a);
            n++;
        end
        if (!a) check_eq("send_timeout", int'(a), 1);
    endtask

    task automatic wait_idle();
        bit a;
        int n;
        n = 0;
        do begin
            step(1'b0, 4'h0, 1'b0, a);
            n++;
        end while (obs[4] && n < 300);
        check_eq("wait_idle_busy", int'(obs[4]), 0);
    endtask

    // Monitor / scoreboard: pops on every EN and tracks the INIT and DONE slots that must follow.
    initial begin
        logic [4:0] e;
        pend_init = 1'b0;
        pend_last = 1'b0;
        pend_done = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                exp_q.delete();
                pend_init = 1'b0;
                pend_done = 1'b0;
                continue;
            end
            if (bus.TEXT_DONE) done_cnt++;
            if (pend_done) begin
                check_eq("text_done_slot", int'({bus.TEXT_DONE, bus.EN, bus.INITIALIZE}), 4);
                pend_done = 1'b0;
            end else begin
                check_eq("no_stray_text_done", int'(bus.TEXT_DONE), 0);
            end
            if (pend_init) begin
                check_eq("init_slot", int'({bus.INITIALIZE, bus.EN, bus.TEXT_DONE}), 4);
                pend_init = 1'b0;
                pend_done = pend_last;
            end else begin
                check_eq("no_stray_init", int'(bus.INITIALIZE), 0);
            end
            if (bus.EN) begin
                if (exp_q.size() == 0) begin
                    check_eq("en_without_pending_symbol", int'(bus.EN), 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("string_order", int'(bus.STRING), int'(e[3:0]));
                    pend_init = 1'b1;
                    pend_last = e[4];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        logic [8:0] t1 [10];
        logic [8:0] t2 [11];
        logic [3:0] s1_sym [3];
        bit         s1_last [3];
        logic [3:0] s2_sym [3];
        bit         s2_last [3];
        logic [3:0] rst_sym [5];
        bit         a;
        bit         found;
        int         snap;
        int         gaps;
`ifdef AC_SYM_POS_EN
        int         p1 [10];
        int         p2 [11];
        p1 = '{-1, -1, 0, -1, 1, -1, 2, -1, -1, -1};
        p2 = '{-1, -1, 0, -1, -1, 0, -1, 1, -1, -1, -1};
`endif
        t1 = '{9'h100, 9'h110, 9'h191, 9'h151, 9'h192, 9'h152, 9'h19A, 9'h15A, 9'h13A,
               9'h10A};
        t2 = '{9'h10A, 9'h11A, 9'h193, 9'h153, 9'h133, 9'h194, 9'h154, 9'h195, 9'h155,
               9'h135, 9'h105};
        s1_sym  = '{4'h1, 4'h2, 4'hA};
        s1_last = '{1'b0, 1'b0, 1'b1};
        s2_sym  = '{4'h3, 4'h4, 4'h5};
        s2_last = '{1'b1, 1'b0, 1'b1};
        rst_sym = '{4'h9, 4'hB, 4'hC, 4'hD, 4'hE};

        RST          = 1'b1;
        bus.IN_VALID = 1'b0;
        bus.IN_SYM   = 4'h0;
        bus.IN_LAST  = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_eq("reset_outputs", int'({bus.IN_READY, bus.EN, bus.INITIALIZE, bus.TEXT_DONE,
                                        bus.BUSY, bus.STRING}), 0);
`ifdef AC_SYM_POS_EN
        check_eq("reset_sym_pos", int'(bus.SYM_POS), 0);
`endif
        @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK);
        #1;

        // Single text 1, 2, A(last): cycle-exact output table.
        for (int i = 0; i < 10; i++) begin
            if (i < 3) step(1'b1, s1_sym[i], s1_last[i], a);
            else       step(1'b0, 4'h0, 1'b0, a);
            check_eq($sformatf("text1_row%0d", i), int'(obs), int'(t1[i]));
`ifdef AC_SYM_POS_EN
            if (p1[i] >= 0) check_eq($sformatf("text1_pos%0d", i), obs_pos, p1[i]);
`endif
        end

        // Back-to-back texts 3(last), then 4, 5(last).
        for (int i = 0; i < 11; i++) begin
            if (i < 3) step(1'b1, s2_sym[i], s2_last[i], a);
            else       step(1'b0, 4'h0, 1'b0, a);
            check_eq($sformatf("b2b_row%0d", i), int'(obs), int'(t2[i]));
`ifdef AC_SYM_POS_EN
            if (p2[i] >= 0) check_eq($sformatf("b2b_pos%0d", i), obs_pos, p2[i]);
`endif
        end

        // Reset during INIT of the second of five buffered symbols.
        for (int i = 0; i < 5; i++) send(rst_sym[i], 1'b0);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge CLK);
            if (bus.INITIALIZE && bus.STRING == 4'hB) found = 1'b1;
        end
        check_eq("reset_init2_found", int'(found), 1);
        #1 RST = 1'b1;
        snap = done_cnt;
        @(negedge CLK);
        check_eq("reset_mid_text_outputs",
                 int'({bus.EN, bus.INITIALIZE, bus.BUSY, bus.TEXT_DONE}), 0);
        @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK);
        #1;
        send(4'h7, 1'b1);
        wait_idle();
        check_eq("reset_single_done_after", done_cnt - snap, 1);
        check_eq("reset_queue_drained", exp_q.size(), 0);

        // Backpressure: a continuous stream overruns the 2-3 cycle drain rate and fills the FIFO.
        acc_cnt  = 0;
        pop_cnt  = 0;
        saw_full = 1'b0;
        chk_occ  = 1'b1;
        for (int i = 0; i < 40; i++) send(4'(i), (i % 8 == 7) || (i == 39));
        chk_occ = 1'b0;
        check_eq("backpressure_reached_full", int'(saw_full), 1);
        wait_idle();
        check_eq("backpressure_queue_drained", exp_q.size(), 0);

        // Wrap-around with random upstream gaps.
        for (int i = 0; i < 40; i++) begin
            gaps = int'($urandom_range(2, 0));
            repeat (gaps) step(1'b0, 4'h0, 1'b0, a);
            send(4'((i * 7 + 3) % 16), (i % 5) == 4);
        end
        wait_idle();
        check_eq("wrap_queue_drained", exp_q.size(), 0);
        // 1 + 2 + 1 + 5 + 8 completed texts
        check_eq("text_done_total", done_cnt, 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
